// File: rtl/tt_um_ronmsjsu_prbs31_ctrl_if.sv
// Tiny Tapeout user-tile pin bundle for the PRBS31 burst sequencer.
//   ena      tile enable (not used by the design)
//   ui_in    dedicated inputs: strobes, rx bit, length code
//   uio_in   bidirectional pins used as inputs (seed byte)
//   uo_out   dedicated outputs: tx, status, checker readout
//   uio_out  bidirectional output values (always 0)
//   uio_oe   bidirectional output enables (always 0, all inputs)
// master: the harness driving the tile; slave: the tile itself.
interface tt_um_ronmsjsu_prbs31_ctrl_if;
    logic       ena;
    logic [7:0] ui_in;
    logic [7:0] uio_in;
    logic [7:0] uo_out;
    logic [7:0] uio_out;
    logic [7:0] uio_oe;

    modport master (
        output ena, ui_in, uio_in,
        input  uo_out, uio_out, uio_oe
    );

    modport slave (
        input  ena, ui_in, uio_in,
        output uo_out, uio_out, uio_oe
    );
endinterface

// File: rtl/tt_um_ronmsjsu_prbs31_ctrl.sv
// PRBS31 burst sequencer (x^31 + x^28 + 1, Fibonacci LFSR).
// The 31-bit seed is shifted in byte-wise from uio_in, bursts are started and
// stopped by pin strobes, and a burst of code*BURST_UNIT bits is followed by a
// one-cycle done flag. Length code 0 runs continuously until stopped.
//
// Ports:
//   clk    tile clock, all state on the rising edge
//   rst_n  asynchronous active-low reset
//   pins   tile pin bundle (slave side):
//          ui_in  [0] start, [1] stop, [2] seed strobe, [3] rx bit, [7:4] length code
//          uio_in seed byte
//          uo_out [0] tx, [1] tx_valid, [2] busy, [3] done, [4] chk_locked, [7:5] err_cnt
//
// Build option: define PRBS_CHECK_EN to include the self-synchronising loopback
// checker on ui_in[3]; without it uo_out[7:4] read as 0.
module tt_um_ronmsjsu_prbs31_ctrl #(
    parameter int BURST_UNIT = 64
) (
    input  logic                               clk,
    input  logic                               rst_n,
    tt_um_ronmsjsu_prbs31_ctrl_if.slave        pins
);
    localparam logic [30:0] DEFAULT_SEED = 31'h7FFF_FFFF;
    localparam logic [15:0] UNIT16       = 16'(BURST_UNIT);

    typedef enum logic [1:0] {S_IDLE, S_RUN, S_DONE} state_t;

    state_t      state_reg, state_next;
    logic [3:0]  sync1_reg, sync2_reg;
    logic [2:0]  prev_reg;
    logic [30:0] seed_reg, lfsr_reg;
    logic [3:0]  len_reg;
    logic [15:0] cnt_reg;
    logic        start_go;

    // Strobe pulses are rising edges of the synchronised pins.
    logic start_pulse, stop_pulse, seed_pulse;
    assign start_pulse = sync2_reg[0] & ~prev_reg[0];
    assign stop_pulse  = sync2_reg[1] & ~prev_reg[1];
    assign seed_pulse  = sync2_reg[2] & ~prev_reg[2];

    // Last count value of a burst; len*BURST_UNIT never exceeds 61440.
    logic [15:0] terminal;
    assign terminal = (16'(len_reg) * UNIT16) - 16'd1;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync1_reg <= '0;
            sync2_reg <= '0;
            prev_reg  <= '0;
        end else begin
            sync1_reg <= pins.ui_in[3:0];
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg[2:0];
        end
    end

    always_comb begin
        state_next = state_reg;
        start_go   = 1'b0;
        case (state_reg)
            S_IDLE: begin
                // Stop beats a simultaneous start.
                if (start_pulse && !stop_pulse) begin
                    state_next = S_RUN;
                    start_go   = 1'b1;
                end
            end
            S_RUN: begin
                // Abort beats a coinciding terminal count.
                if (stop_pulse)
                    state_next = S_IDLE;
                else if (len_reg != 4'd0 && cnt_reg == terminal)
                    state_next = S_DONE;
            end
            S_DONE:  state_next = S_IDLE;
            default: state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg <= S_IDLE;
            seed_reg  <= DEFAULT_SEED;
            lfsr_reg  <= DEFAULT_SEED;
            len_reg   <= '0;
            cnt_reg   <= '0;
        end else begin
            state_reg <= state_next;
            if (state_reg == S_IDLE && seed_pulse)
                seed_reg <= {seed_reg[22:0], pins.uio_in};
            if (start_go) begin
                // A zero seed would lock the LFSR; substitute the default.
                lfsr_reg <= (seed_reg == 31'd0) ? DEFAULT_SEED : seed_reg;
                len_reg  <= pins.ui_in[7:4];
                cnt_reg  <= '0;
            end else if (state_reg == S_RUN) begin
                lfsr_reg <= {lfsr_reg[29:0], lfsr_reg[30] ^ lfsr_reg[27]};
                cnt_reg  <= cnt_reg + 16'd1;
            end
        end
    end

    logic tx_valid, busy, done, tx_bit;
    assign tx_valid = (state_reg == S_RUN);
    assign busy     = tx_valid;
    assign done     = (state_reg == S_DONE);
    assign tx_bit   = tx_valid & lfsr_reg[30];

`ifdef PRBS_CHECK_EN
    logic [30:0] chk_reg;
    logic [4:0]  chk_cnt_reg;
    logic        chk_locked_reg;
    logic [2:0]  err_cnt_reg;
    logic        rx_bit;
    assign rx_bit = sync2_reg[3];

    // Self-synchronising: the history register is filled from the received
    // stream itself, so any contiguous PRBS31 segment checks clean once 31
    // samples are in.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            chk_reg        <= '0;
            chk_cnt_reg    <= '0;
            chk_locked_reg <= 1'b0;
            err_cnt_reg    <= '0;
        end else if (start_go) begin
            chk_reg        <= '0;
            chk_cnt_reg    <= '0;
            chk_locked_reg <= 1'b0;
            err_cnt_reg    <= '0;
        end else if (state_reg == S_RUN) begin
            chk_reg <= {chk_reg[29:0], rx_bit};
            if (!chk_locked_reg) begin
                chk_cnt_reg <= chk_cnt_reg + 5'd1;
                if (chk_cnt_reg == 5'd30)
                    chk_locked_reg <= 1'b1;
            end else if ((rx_bit != (chk_reg[30] ^ chk_reg[27])) && err_cnt_reg != 3'd7) begin
                err_cnt_reg <= err_cnt_reg + 3'd1;
            end
        end
    end

    assign pins.uo_out = {err_cnt_reg, chk_locked_reg, done, busy, tx_valid, tx_bit};

    logic unused_pins;
    assign unused_pins = pins.ena;
`else
    assign pins.uo_out = {4'b0000, done, busy, tx_valid, tx_bit};

    logic unused_pins;
    assign unused_pins = ^{pins.ena, sync2_reg[3]};
`endif

    assign pins.uio_out = 8'h00;
    assign pins.uio_oe  = 8'h00;
endmodule

// File: tb/tb_tt_um_ronmsjsu_prbs31_ctrl.sv
// Directed testbench for the PRBS31 burst sequencer tile.
module tb_tt_um_ronmsjsu_prbs31_ctrl;
    logic clk;
    logic rst_n;

    tt_um_ronmsjsu_prbs31_ctrl_if dut_if();

    tt_um_ronmsjsu_prbs31_ctrl #(.BURST_UNIT(64)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .pins  (dut_if)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_bad    = 0;
    logic        bits     [0:4095];
    logic        ref_bits [0:63];
    logic [30:0] rx_lfsr  = 31'h1234_5678;
    logic        rx_en    = 1'b0;
    logic        rx_flip  = 1'b0;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    // Advance one clock; when enabled, the rx pin carries a free-running PRBS31
    // stream (optionally with one bit inverted).
    task automatic tick();
        if (rx_en) begin
            dut_if.ui_in[3] = rx_lfsr[30] ^ rx_flip;
            rx_flip = 1'b0;
            rx_lfsr = {rx_lfsr[29:0], rx_lfsr[30] ^ rx_lfsr[27]};
        end
        @(posedge clk);
        #1;
    endtask

    task automatic ticks(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    // Pin rises before edge E0; tx_valid must appear after the third edge.
    task automatic do_start(input logic [3:0] code, input string tag);
        dut_if.ui_in[7:4] = code;
        dut_if.ui_in[0]   = 1'b1;
        tick();
        dut_if.ui_in[0]   = 1'b0;
        tick();
        check_eq({tag, " valid early"}, 32'(dut_if.uo_out[1]), 32'd0);
        tick();
        check_eq({tag, " valid+busy"}, 32'(dut_if.uo_out[2:1]), 32'd3);
    endtask

    task automatic seed_byte(input logic [7:0] b);
        dut_if.uio_in   = b;
        dut_if.ui_in[2] = 1'b1;
        tick();
        dut_if.ui_in[2] = 1'b0;
        ticks(4);
    endtask

    // Record tx bits while tx_valid is high; optionally raise stop or seed
    // strobe while recording bit index stop_at / seed_at.
    task automatic collect(input int stop_at, input int seed_at, output int n);
        n = 0;
        while (dut_if.uo_out[1] && n < 4096) begin
            bits[n] = dut_if.uo_out[0];
            dut_if.ui_in[1] = (n == stop_at);
            dut_if.ui_in[2] = (n == seed_at);
            n++;
            tick();
        end
        dut_if.ui_in[1] = 1'b0;
        dut_if.ui_in[2] = 1'b0;
        $display("burst: %0d valid bits, first bits %b%b%b%b", n, bits[0], bits[1], bits[2], bits[3]);
    endtask

    // Number of recorded bits that differ from the reference x^31+x^28+1 sequence.
    function automatic int model_errs(input logic [30:0] seed, input int n);
        logic [30:0] s;
        int          e;
        s = seed;
        e = 0;
        for (int i = 0; i < n; i++) begin
            if (bits[i] !== s[30]) e++;
            s = {s[29:0], s[30] ^ s[27]};
        end
        return e;
    endfunction

    initial begin
        int n;
        int ones;
        int diffs;

        rst_n          = 1'b0;
        dut_if.ena     = 1'b1;
        dut_if.ui_in   = 8'h00;
        dut_if.uio_in  = 8'h00;
        ticks(3);
        check_eq("t1 reset uo_out", 32'(dut_if.uo_out), 32'h00);
        check_eq("t1 reset uio_out", 32'(dut_if.uio_out), 32'h00);
        check_eq("t1 reset uio_oe", 32'(dut_if.uio_oe), 32'h00);
        rst_n = 1'b1;
        ticks(3);
        check_eq("t1 idle after release", 32'(dut_if.uo_out), 32'h00);

        // T1: asynchronous reset in the middle of a burst.
        do_start(4'd1, "t1");
        ticks(10);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("t1 async clear", 32'(dut_if.uo_out), 32'h00);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        ticks(3);
        check_eq("t1 idle no done", 32'(dut_if.uo_out), 32'h00);

        // T2: default seed, 64-bit burst.
        do_start(4'd1, "t2");
        collect(-1, -1, n);
        check_eq("t2 length", 32'(n), 32'd64);
        ones = 0;
        for (int i = 0; i < 31; i++) ones += int'(bits[i]);
        check_eq("t2 first 31 ones", 32'(ones), 32'd31);
        check_eq("t2 bit32", 32'(bits[31]), 32'd0);
        check_eq("t2 model", 32'(model_errs(31'h7FFF_FFFF, 64)), 32'd0);
        check_eq("t2 done/busy/valid", 32'(dut_if.uo_out[3:0]), 32'b1000);
        tick();
        check_eq("t2 done one cycle", 32'(dut_if.uo_out[3:0]), 32'b0000);

        // T3: seed = 1, 128-bit burst.
        seed_byte(8'h00);
        seed_byte(8'h00);
        seed_byte(8'h00);
        seed_byte(8'h01);
        do_start(4'd2, "t3");
        collect(-1, -1, n);
        check_eq("t3 length", 32'(n), 32'd128);
        ones = 0;
        for (int i = 0; i < 30; i++) ones += int'(bits[i]);
        check_eq("t3 first 30 zeros", 32'(ones), 32'd0);
        check_eq("t3 bit31", 32'(bits[30]), 32'd1);
        check_eq("t3 model", 32'(model_errs(31'd1, 128)), 32'd0);
        check_eq("t3 done", 32'(dut_if.uo_out[3]), 32'd1);
        tick();

        // T4: continuous burst aborted; stop pin raised while bit 499 is out,
        // so bits 500 and 501 still go out before the abort.
        do_start(4'd0, "t4");
        collect(499, -1, n);
        check_eq("t4 length", 32'(n), 32'd502);
        check_eq("t4 no done, idle", 32'(dut_if.uo_out[3:0]), 32'b0000);
        for (int i = 0; i < 64; i++) ref_bits[i] = bits[i];
        ticks(2);
        check_eq("t4 still no done", 32'(dut_if.uo_out[3]), 32'd0);
        do_start(4'd1, "t4b");
        collect(-1, -1, n);
        diffs = 0;
        for (int i = 0; i < 64; i++) if (bits[i] !== ref_bits[i]) diffs++;
        check_eq("t4 repeat length", 32'(n), 32'd64);
        check_eq("t4 repeat bits", 32'(diffs), 32'd0);
        tick();

        // T5: start and stop together in IDLE, then seed strobe during RUN.
        dut_if.ui_in[1:0] = 2'b11;
        tick();
        dut_if.ui_in[1:0] = 2'b00;
        ticks(2);
        check_eq("t5 start+stop idle a", 32'(dut_if.uo_out[2:1]), 32'd0);
        ticks(3);
        check_eq("t5 start+stop idle b", 32'(dut_if.uo_out[2:1]), 32'd0);
        dut_if.uio_in = 8'hAA;
        do_start(4'd1, "t5");
        collect(-1, 5, n);
        check_eq("t5 length with seed strobe", 32'(n), 32'd64);
        ticks(3);
        do_start(4'd1, "t5b");
        collect(-1, -1, n);
        check_eq("t5 seed unchanged", 32'(model_errs(31'd1, 64)), 32'd0);
        tick();

`ifdef PRBS_CHECK_EN
        // T6: rx carries a continuous PRBS31 stream, so the checker sees a
        // contiguous sequence; inverted bits must register as errors.
        rx_en = 1'b1;
        ticks(4);
        do_start(4'd4, "t6");
        check_eq("t6 unlocked at start", 32'(dut_if.uo_out[7:4]), 32'd0);
        n = 0;
        while (dut_if.uo_out[1] && n < 400) begin
            if (n == 90) check_eq("t6 locked clean", 32'(dut_if.uo_out[7:4]), 32'b0001);
            if (n == 100 || n == 140 || n == 180) rx_flip = 1'b1;
            n++;
            tick();
        end
        check_eq("t6 burst length", 32'(n), 32'd256);
        check_eq("t6 err>=3", 32'(dut_if.uo_out[7:5] >= 3'd3), 32'd1);
        check_eq("t6 locked held", 32'(dut_if.uo_out[4]), 32'd1);
        ticks(2);
        do_start(4'd4, "t6b");
        check_eq("t6b cleared", 32'(dut_if.uo_out[7:4]), 32'd0);
        n = 0;
        while (dut_if.uo_out[1] && n < 400) begin
            if (n >= 40 && n < 140 && (n % 5) == 0) rx_flip = 1'b1;
            n++;
            tick();
        end
        ticks(3);
        check_eq("t6 err saturates", 32'(dut_if.uo_out[7:5]), 32'd7);
        check_eq("t6 locked in idle", 32'(dut_if.uo_out[4]), 32'd1);
        rx_en = 1'b0;
`endif

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end
endmodule
